// File: rtl/cfg_pkg.sv
// Shared types and defaults for the configuration chain loader.
package cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_FINISH
    } state_t;

    localparam int unsigned CFG_CHAIN_LEN = 1480;
    localparam int unsigned CFG_WORD_W    = 32;
    localparam int unsigned CFG_CLK_DIV   = 2;

    // Width of an index over n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cfg_clk_gen.sv
// Phase counter for the programming clock: strobes on the last clk cycle of each phase.
module cfg_clk_gen
    import cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV = CFG_CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic phase_done
);

    localparam int unsigned CW = idx_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign phase_done = run && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!run || phase_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams a word-wide bitstream into the fabric configuration shift chain,
// generating prog_clk and optionally checking the bits shifted out.
module cfg_chain_loader
    import cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN   = CFG_CHAIN_LEN,
    parameter int unsigned WORD_W      = CFG_WORD_W,
    parameter int unsigned CLK_DIV     = CFG_CLK_DIV,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           verify_en,
    input  logic                           abort,
    input  logic [WORD_W-1:0]              word_in,
    input  logic [WORD_W-1:0]              exp_word,
    input  logic                           word_valid,
    output logic                           word_ready,
    input  logic                           prog_out,
    output logic                           prog_in,
    output logic                           prog_clk,
    output logic                           prog_en,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [idx_width(CHAIN_LEN)-1:0] err_index
);

    localparam int unsigned IW = idx_width(CHAIN_LEN);
    localparam int unsigned BW = idx_width(WORD_W);
    localparam logic [IW-1:0] LAST_BIT  = IW'(CHAIN_LEN - 1);
    localparam logic [BW-1:0] LAST_WBIT = BW'(WORD_W - 1);

    state_t            state, state_nx;
    logic [WORD_W-1:0] new_sr, exp_sr, new_shift;
    logic [IW-1:0]     bit_cnt;
    logic [BW-1:0]     wbit_cnt;
    logic              verify_lat;
    logic              phase_run, phase_done;
    logic              mism, active_nx;

    assign phase_run = (state == ST_HIGH) || (state == ST_LOW);
    assign new_shift = new_sr >> 1;
    // prog_out still shows the old chain bit here: compare precedes the shift.
    assign mism      = verify_lat && (prog_out != exp_sr[0]);

    cfg_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (phase_run),
        .phase_done (phase_done)
    );

    always_comb begin
        state_nx  = state;
        active_nx = 1'b0;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start) state_nx = ST_FETCH;
                ST_FETCH:  if (word_valid) state_nx = ST_SETUP;
                ST_SETUP:  state_nx = (STOP_ON_ERR && mism) ? ST_FINISH : ST_HIGH;
                ST_HIGH:   if (phase_done) state_nx = ST_LOW;
                ST_LOW: begin
                    if (phase_done) begin
                        if (bit_cnt == LAST_BIT)        state_nx = ST_FINISH;
                        else if (wbit_cnt == LAST_WBIT) state_nx = ST_FETCH;
                        else                            state_nx = ST_SETUP;
                    end
                end
                ST_FINISH: state_nx = ST_IDLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
        active_nx = (state_nx == ST_FETCH) || (state_nx == ST_SETUP) ||
                    (state_nx == ST_HIGH)  || (state_nx == ST_LOW);
    end

    // Outputs are registered from the next-state decode so they align with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            new_sr     <= '0;
            exp_sr     <= '0;
            bit_cnt    <= '0;
            wbit_cnt   <= '0;
            verify_lat <= 1'b0;
            prog_in    <= 1'b0;
            prog_clk   <= 1'b0;
            prog_en    <= 1'b0;
            word_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_index  <= '0;
        end else begin
            state      <= state_nx;
            prog_clk   <= (state_nx == ST_HIGH);
            word_ready <= (state_nx == ST_FETCH);
            busy       <= active_nx;
            prog_en    <= active_nx;
            done       <= (state_nx == ST_FINISH);

            if (state == ST_IDLE && state_nx == ST_FETCH) begin
                error      <= 1'b0;
                err_index  <= '0;
                bit_cnt    <= '0;
                verify_lat <= verify_en;
            end
            if (state == ST_FETCH && state_nx == ST_SETUP) begin
                new_sr   <= word_in;
                exp_sr   <= exp_word;
                prog_in  <= word_in[0];
                wbit_cnt <= '0;
            end
            if (state == ST_SETUP && mism && !error) begin
                error     <= 1'b1;
                err_index <= bit_cnt;
            end
            if (state == ST_LOW && phase_done) begin
                new_sr   <= new_shift;
                exp_sr   <= exp_sr >> 1;
                bit_cnt  <= bit_cnt + 1'b1;
                wbit_cnt <= wbit_cnt + 1'b1;
                if (state_nx == ST_SETUP) prog_in <= new_shift[0];
            end
        end
    end

endmodule
